// File: rtl/sha_mem_sequencer_pkg.sv
// sha_seq_pkg: shared widths, block geometry and the sequencer state type
// used by the SHA memory sequencer, its RAM/core bus interface and the
// RAM port multiplexer.
package sha_seq_pkg;

    localparam int ADDR_W       = 12;  // RAM word-address width
    localparam int DATA_W       = 32;  // RAM and core word width
    localparam int BLOCK_WORDS  = 16;  // words per message block
    localparam int DIGEST_WORDS = 8;   // words per digest
    localparam int IDX_W        = 4;   // word index counter width

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_DRAIN,
        S_KICK,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/sha_mem_sequencer_if.sv
// sha_mem_sequencer_if: RAM port and SHA core handshake signals.
//   master - sequencer side: drives RAM address/write and core load/start/select
//   slave  - RAM + core side: returns read data, readiness and digest words
interface sha_mem_sequencer_if;
    import sha_seq_pkg::*;

    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    logic              core_ready;
    logic              core_load;
    logic [DATA_W-1:0] core_word;
    logic              core_start;
    logic              core_digest_valid;
    logic [2:0]        core_digest_sel;
    logic [DATA_W-1:0] core_digest_word;

    modport master (
        output ram_wEn, ram_addr, ram_dataIn,
        output core_load, core_word, core_start, core_digest_sel,
        input  ram_dataOut, core_ready, core_digest_valid, core_digest_word
    );

    modport slave (
        input  ram_wEn, ram_addr, ram_dataIn,
        input  core_load, core_word, core_start, core_digest_sel,
        output ram_dataOut, core_ready, core_digest_valid, core_digest_word
    );

endinterface

// File: rtl/sha_mem_sequencer_ram_port_mux.sv
// ram_port_mux: combinational selection of the single RAM port.
//   own            - 1: sequencer drives RAM, processor write is blocked
//   cpu_*          - processor write enable / address / data
//   seq_*          - sequencer write enable / address / data
//   ram_*          - resulting RAM write enable / address / data
module ram_port_mux
    import sha_seq_pkg::*;
(
    input  logic              own,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              seq_wren,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [DATA_W-1:0] seq_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data
);

    always_comb begin
        if (own) begin
            ram_wren = seq_wren;
            ram_addr = seq_addr;
            ram_data = seq_data;
        end else begin
            ram_wren = cpu_wren;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end
    end

endmodule

// File: rtl/sha_mem_sequencer.sv
// sha_mem_sequencer: copies one 512-bit message block from RAM into the SHA
// core, starts compression and writes the 8-word digest back to RAM.
//   clock, reset          - system clock, asynchronous active-low reset
//   start, src_addr,
//   dst_addr              - command pulse with block source / digest destination
//   busy, done            - not-idle flag, one-cycle completion pulse
//   cpu_wren/addr/data    - processor RAM port, passed through when not owned
//   cpu_stall             - processor must hold while the sequencer owns RAM
//   bus                   - RAM port and SHA core handshake (master side)
module sha_mem_sequencer
    import sha_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    sha_mem_sequencer_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_FETCH = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_WRITE = IDX_W'(DIGEST_WORDS - 1);

    state_t            state, next_state;
    logic [IDX_W-1:0]  idx, next_idx;
    logic [ADDR_W-1:0] src_base, dst_base;

    logic              own;
    logic              seq_wren;
    logic [ADDR_W-1:0] seq_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            src_base <= '0;
            dst_base <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            if (state == S_IDLE && start) begin
                src_base <= src_addr;
                dst_base <= dst_addr;
            end
        end
    end

    always_comb begin
        next_state          = state;
        next_idx            = idx;
        busy                = 1'b1;
        done                = 1'b0;
        own                 = 1'b0;
        seq_wren            = 1'b0;
        seq_addr            = '0;
        bus.core_load       = 1'b0;
        bus.core_start      = 1'b0;
        bus.core_digest_sel = '0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = S_ARM;
                    next_idx   = '0;
                end
            end
            S_ARM: begin
                // Readiness is sampled only here; a later drop is ignored.
                if (bus.core_ready) next_state = S_FETCH;
            end
            S_FETCH: begin
                own      = 1'b1;
                // RAM read data lags its address by one cycle, so the word
                // handed to the core is always the previous index.
                seq_addr = src_base + ADDR_W'(idx);
                bus.core_load = (idx != '0);
                if (idx == LAST_FETCH) begin
                    next_state = S_DRAIN;
                    next_idx   = '0;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
            S_DRAIN: begin
                own           = 1'b1;
                bus.core_load = 1'b1;
                next_state    = S_KICK;
            end
            S_KICK: begin
                bus.core_start = 1'b1;
                next_state     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_digest_valid) begin
                    next_state = S_WRITE;
                    next_idx   = '0;
                end
            end
            S_WRITE: begin
                own                 = 1'b1;
                seq_wren            = 1'b1;
                seq_addr            = dst_base + ADDR_W'(idx);
                bus.core_digest_sel = idx[2:0];
                if (idx == LAST_WRITE) begin
                    next_state = S_DONE;
                    next_idx   = '0;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
                next_idx   = '0;
            end
        endcase
    end

    assign cpu_stall     = own;
    assign bus.core_word = bus.ram_dataOut;

    ram_port_mux u_ram_port_mux (
        .own      (own),
        .cpu_wren (cpu_wren),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .seq_wren (seq_wren),
        .seq_addr (seq_addr),
        .seq_data (bus.core_digest_word),
        .ram_wren (bus.ram_wEn),
        .ram_addr (bus.ram_addr),
        .ram_data (bus.ram_dataIn)
    );

endmodule

// File: tb/tb_sha_mem_sequencer.sv
// tb_sha_mem_sequencer: directed bench with a RAM model and an echoing SHA
// core model (digest word i = block word i XOR block word i+8).
module tb_sha_mem_sequencer;
    import sha_seq_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              busy, done;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_stall;

    always #5 clock = ~clock;

    sha_mem_sequencer_if bus();

    sha_mem_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .busy      (busy),
        .done      (done),
        .cpu_wren  (cpu_wren),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_stall (cpu_stall),
        .bus       (bus.master)
    );

    // RAM model: synchronous read, one cycle latency
    logic [DATA_W-1:0] mem [0:4095];
    logic [DATA_W-1:0] rd_data;
    always @(posedge clock) begin
        rd_data <= mem[bus.ram_addr];
        if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    end
    assign bus.ram_dataOut = rd_data;

    // Core model
    logic [DATA_W-1:0] rx [0:15];
    int   rx_n = 0;
    logic prev_load = 1'b0;
    int   start_n = 0;
    int   dcnt = 0;
    int   digest_delay = 0;
    logic digest_valid = 1'b0;
    logic core_rdy = 1'b1;
    assign bus.core_ready        = core_rdy;
    assign bus.core_digest_valid = digest_valid;
    assign bus.core_digest_word  = rx[{1'b0, bus.core_digest_sel}] ^ rx[{1'b1, bus.core_digest_sel}];

    always @(posedge clock) begin
        prev_load <= bus.core_load;
        if (bus.core_load) begin
            if (!prev_load) begin
                rx[0] <= bus.core_word;
                rx_n  <= 1;
            end else if (rx_n < 16) begin
                rx[rx_n[3:0]] <= bus.core_word;
                rx_n <= rx_n + 1;
            end
        end
        if (bus.core_start) begin
            start_n <= start_n + 1;
            if (digest_delay == 0) digest_valid <= 1'b1;
            else begin
                digest_valid <= 1'b0;
                dcnt <= digest_delay;
            end
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) digest_valid <= 1'b1;
        end
    end

    // Bus monitor
    logic [ADDR_W-1:0] rd_log [0:511];
    logic [ADDR_W-1:0] wr_addr_log [0:511];
    logic [DATA_W-1:0] wr_data_log [0:511];
    int run_len [0:63];
    int rd_n = 0, wr_n = 0, cw_n = 0, stall_run = 0, run_n = 0;
    always @(posedge clock) begin
        if (cpu_stall && !bus.ram_wEn && rd_n < 512) begin
            rd_log[rd_n] <= bus.ram_addr;
            rd_n <= rd_n + 1;
        end
        if (cpu_stall && bus.ram_wEn && wr_n < 512) begin
            wr_addr_log[wr_n] <= bus.ram_addr;
            wr_data_log[wr_n] <= bus.ram_dataIn;
            wr_n <= wr_n + 1;
        end
        if (!cpu_stall && bus.ram_wEn && bus.ram_addr == 12'h050) cw_n <= cw_n + 1;
        if (cpu_stall) stall_run <= stall_run + 1;
        else if (stall_run != 0) begin
            if (run_n < 64) run_len[run_n] <= stall_run;
            run_n <= run_n + 1;
            stall_run <= 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clock);
        cpu_wren = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        @(negedge clock);
        cpu_wren = 1'b0;
    endtask

    // One command; cycle k is the cycle after the k-th edge past the accept edge.
    task automatic run(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                       input int ready_dly, input int dig_dly, input bit inject, input bit hammer,
                       output int done_cyc, output int first_load, output int last_load,
                       output int stall_in_arm, output int busy_low);
        int cyc;
        digest_delay = dig_dly;
        @(negedge clock);
        src_addr = s;
        dst_addr = d;
        start    = 1'b1;
        core_rdy = (ready_dly == 0);
        if (hammer) begin
            cpu_wren = 1'b1;
            cpu_addr = 12'h050;
            cpu_data = 32'h0000_DEAD;
        end
        @(posedge clock);
        done_cyc = -1; first_load = -1; last_load = -1;
        stall_in_arm = 0; busy_low = 0; cyc = 0;
        while (cyc < 400) begin
            @(negedge clock);
            cyc++;
            start    = inject && (cyc == 5);
            src_addr = (inject && cyc == 5) ? 12'h300 : s;
            core_rdy = (cyc > ready_dly);
            if (cyc <= ready_dly && cpu_stall) stall_in_arm++;
            if (!busy) busy_low++;
            if (bus.core_load) begin
                if (first_load < 0) first_load = cyc;
                last_load = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        cpu_wren = 1'b0;
    endtask

    logic [DATA_W-1:0] blk     [16] = '{32'h6162_6380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h18};
    logic [DATA_W-1:0] blk_dig [8]  = '{32'h6162_6380, 0, 0, 0, 0, 0, 0, 32'h18};
    logic [ADDR_W-1:0] wrap_rd [16] = '{12'hFFA, 12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF,
                                        12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                                        12'h006, 12'h007, 12'h008, 12'h009};
    logic [ADDR_W-1:0] wrap_wr [8]  = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF,
                                        12'h000, 12'h001, 12'h002, 12'h003};

    initial begin
        int dc, fl, ll, sa, bl;
        int rb, wb, sb, cb, rs;
        start = 1'b0; src_addr = '0; dst_addr = '0;
        cpu_wren = 1'b0; cpu_addr = 12'h123; cpu_data = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_load", 64'(bus.core_load), 64'd0);
        check("rst_cstart", 64'(bus.core_start), 64'd0);
        check("rst_wen", 64'(bus.ram_wEn), 64'd0);
        check("rst_sel", 64'(bus.core_digest_sel), 64'd0);
        check("rst_passthru", 64'(bus.ram_addr), 64'h123);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) cpu_write(12'h100 + 12'(i), blk[i]);
        for (int i = 0; i < 8; i++) cpu_write(12'h200 + 12'(i), 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) cpu_write(wrap_rd[i], 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 8; i++) cpu_write(12'h230 + 12'(i), 32'hFFFF_FFFF);
        cpu_write(12'h050, 32'h0);

        // Block load + arbitration
        sb = start_n; cb = cw_n; rs = run_n;
        run(12'h100, 12'h200, 0, 0, 1'b0, 1'b1, dc, fl, ll, sa, bl);
        check("blk_done_cyc", 64'(dc), 64'd29);
        check("blk_first_load", 64'(fl), 64'd3);
        check("blk_last_load", 64'(ll), 64'd18);
        check("blk_core_start", 64'(start_n - sb), 64'd1);
        check("blk_idle_after", 64'(busy), 64'd0);
        for (int i = 0; i < 16; i++) check($sformatf("blk_rx%0d", i), 64'(rx[i]), 64'(blk[i]));
        for (int i = 0; i < 8; i++)
            check($sformatf("blk_dig%0d", i), 64'(mem[12'h200 + 12'(i)]), 64'(blk_dig[i]));
        check("arb_cpu_writes", 64'(cw_n - cb), 64'd5);
        check("arb_cpu_data", 64'(mem[12'h050]), 64'h0000_DEAD);
        check("arb_stall_run1", 64'(run_len[rs]), 64'd17);
        check("arb_stall_run2", 64'(run_len[rs + 1]), 64'd8);

        // Address wrap
        rb = rd_n; wb = wr_n;
        run(12'hFFA, 12'hFFC, 0, 0, 1'b0, 1'b0, dc, fl, ll, sa, bl);
        check("wrap_done_cyc", 64'(dc), 64'd29);
        for (int i = 0; i < 16; i++)
            check($sformatf("wrap_rd%0d", i), 64'(rd_log[rb + i]), 64'(wrap_rd[i]));
        check("wrap_rx6", 64'(rx[6]), 64'h1000_0006);
        check("wrap_rx15", 64'(rx[15]), 64'h1000_000F);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_wr%0d", i), 64'(wr_addr_log[wb + i]), 64'(wrap_wr[i]));
            check($sformatf("wrap_wd%0d", i), 64'(wr_data_log[wb + i]), 64'h8);
        end

        // Handshake stalls
        run(12'h100, 12'h220, 5, 64, 1'b0, 1'b0, dc, fl, ll, sa, bl);
        check("hs_stall_in_arm", 64'(sa), 64'd0);
        check("hs_first_load", 64'(fl), 64'd8);
        check("hs_busy_low", 64'(bl), 64'd0);
        check("hs_done_cyc", 64'(dc), 64'd98);
        check("hs_dig0", 64'(mem[12'h220]), 64'h6162_6380);

        // Start while busy
        rb = rd_n;
        run(12'h100, 12'h210, 0, 0, 1'b1, 1'b0, dc, fl, ll, sa, bl);
        check("bsy_done_cyc", 64'(dc), 64'd29);
        for (int i = 0; i < 16; i++)
            check($sformatf("bsy_rd%0d", i), 64'(rd_log[rb + i]), 64'(12'h100 + 12'(i)));

        // Async reset during write-back
        wb = wr_n;
        @(negedge clock);
        src_addr = 12'h100; dst_addr = 12'h230; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (wr_n - wb == 3) break;
            @(negedge clock);
        end
        check("ar_reached_idx3", 64'(wr_n - wb), 64'd3);
        reset = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_wen", 64'(bus.ram_wEn), 64'd0);
        check("ar_stall", 64'(cpu_stall), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        check("ar_mem0", 64'(mem[12'h230]), 64'h6162_6380);
        check("ar_mem1", 64'(mem[12'h231]), 64'h0);
        check("ar_mem2", 64'(mem[12'h232]), 64'h0);
        for (int i = 3; i < 8; i++)
            check($sformatf("ar_keep%0d", i), 64'(mem[12'h230 + 12'(i)]), 64'hFFFF_FFFF);

        // Normal run after reset release
        run(12'h100, 12'h240, 0, 0, 1'b0, 1'b0, dc, fl, ll, sa, bl);
        check("post_done_cyc", 64'(dc), 64'd29);
        check("post_dig0", 64'(mem[12'h240]), 64'h6162_6380);
        check("post_dig7", 64'(mem[12'h247]), 64'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
